dfi_dram_model: RTL and testbench
=================================

# dfi_dram_model

Responder side of the 32-bit DFI command/data interface: a synthesizable single-rank DDR3 device model that decodes CS#/RAS#/CAS#/WE# commands, tracks init, mode registers and per-bank open rows, and serves 4-beat (128-bit) read and write bursts from an internal array. It sits opposite the DRAM controller in simulation and FPGA loopback builds, in place of the PHY and the external part. It also checks controller protocol timing and latches the first violation as a sticky error.

## Interface
- `CL`, 6: read latency, in cycles from the READ command to beat 0.
- `CWL`, 6: write latency, in cycles from the WRITE command to beat 0.
- `T_RCD`, 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
- `T_RFC`, 27: cycles after REFRESH in which only NOP is legal.
- `ROW_BITS`, 4: low row-address bits used to index the array.
- `COL_BITS`, 7: burst-aligned column bits, taken from `dfi_addr[9:3]`.
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `dfi_addr`  in  15  row (ACTIVE), column plus A10 (READ/WRITE), or MR value (MRS).
- `dfi_bank`  in  3  bank, or MR select for MRS.
- `dfi_csn`, `dfi_rasn`, `dfi_casn`, `dfi_wen`  in  1 each  command, decoded as {csn,rasn,casn,wen}.
- `dfi_cke`  in  1  clock enable; while it is low, all commands are ignored.
- `dfi_rstn`  in  1  device reset, sampled synchronously.
- `dfi_wdata`  in  32  write beat.
- `dfi_wmask`  in  1  write-data valid.
- `dfi_rdata`  out  32  read beat; 0 when no beat is being driven.
- `init_done`  out  1  high once MR2, MR3, MR1, MR0 and ZQCL have all been seen.
- `err`  out  1  sticky protocol-error flag.
- `err_code`  out  3  code of the first error; 0 means no error.

## Operation
- **Command decode:** NOP=0111, MRS=0000, ZQCL=0110, REFRESH=0001, ACTIVE=0011, READ=0101, WRITE=0100. Any other code counts as a NOP.
- **Init FSM:**
  - RESET: entered while `dfi_rstn`=0 → CKE_WAIT.
  - CKE_WAIT: → CONFIG on the first cycle with `dfi_cke`=1.
  - CONFIG: MRS writes `mr[dfi_bank[1:0]]` and sets a seen bit for that register. ZQCL sets zq_seen. → READY when all four seen bits and zq_seen are set.
- **`init_done`:** equals (state==READY).
- **Illegal commands before READY:** ACTIVE, READ, WRITE or REFRESH outside READY raises err 1, and the command is dropped.
- **ACTIVE:** if the bank is open → err 2 and the command is dropped. Otherwise: open[bank]=1, row[bank]=`dfi_addr[ROW_BITS-1:0]`, and the bank's tRCD counter loads T_RCD.
- **READ/WRITE checks:**
  - Bank closed → err 3.
  - tRCD counter nonzero → err 4.
  - Burst slot busy → err 6.
  - Any of these drops the command.
- **READ/WRITE accepted:** latch the array index {bank, row[bank], `dfi_addr[9:3]`} and the direction, then load the burst counter. If A10=1, clear open[bank] (auto-precharge).
- **REFRESH:**
  - Any bank open → err 3.
  - Otherwise load the tRFC counter.
  - Any command other than NOP while the tRFC counter is nonzero → err 5, and that command is dropped.
- **Read burst:** array word w is read at acceptance. `dfi_rdata` = w[32i+31:32i] during cycle C+CL+i, for i=0..3, where C is the command cycle. Beat 0 is the least-significant word.
- **Write burst:**
  - In cycle C+CWL+i (i=0..3), `dfi_wdata` is merged into word slice i.
  - If `dfi_wmask`=0 in a beat cycle → err 7 and that slice keeps its old value.
  - The array is written on the edge ending beat 3.
  - `dfi_wmask`/`dfi_wdata` outside the 4 beat cycles are ignored; trailing high-mask cycles are legal.
- **Burst slot:** a single slot, busy from acceptance through the last beat. A new READ/WRITE becomes legal in the cycle after the last beat.
- **Error latching:** `err`/`err_code` latch the first error only; later errors do not overwrite `err_code`. A new READ/WRITE that is dropped does not disturb an in-flight burst.
- **Sync reset:** `dfi_rstn`=0 at any time → state RESET; clears mode seen bits, open banks, the burst slot and all counters. Array contents and err are kept.

## Timing
- **Async reset (`rstn`=0):** `dfi_rdata`=0, `init_done`=0, `err`=0, `err_code`=0. The FSM goes to RESET and all banks close. The array is not cleared.
- **Registered outputs:** all outputs are registered. `dfi_rdata` beat i is valid for exactly one cycle.
- **Same-edge capture:** inputs are sampled on the rising edge. A command is acted on at the edge that ends its cycle.
- **Counters:** tRCD and tRFC counters decrement once per cycle, saturating at 0. A READ in cycle C+T_RCD after ACTIVE in cycle C is legal.
- **Read of a fresh write:** a READ accepted after a write's beat 3 returns the new data.
- **Burst during sync reset:** if `dfi_rstn` falls during a burst, the burst aborts immediately, no array write occurs, and `dfi_rdata` returns to 0 the next cycle.

## Test plan
- **Init:** `dfi_rstn`↑, `dfi_cke`↑, MRS to MR2, MR3, MR1, MR0 (MR0=0x0310), then ZQCL → `init_done`=1 the cycle after ZQCL; `err`=0.
- **Write then read:**
  - Sequence: ACTIVE bank 3 row 5; WRITE col 0x10|A10 two cycles later; four beats 0x11111111…0x44444444 with `dfi_wmask` held high for 9 cycles; then ACTIVE and READ at the same address.
  - Required response: `dfi_rdata` = 0x11111111, 0x22222222, 0x33333333, 0x44444444 in cycles C+6..C+9, and 0 elsewhere.
- **Early READ:** READ one cycle after ACTIVE → `err`=1, `err_code`=4, `dfi_rdata` stays 0.
- **Double ACTIVE:** ACTIVE twice to bank 0 without auto-precharge → `err_code`=2.
- **Refresh window:** REFRESH, then ACTIVE 10 cycles later → `err_code`=5. After async reset, repeat with ACTIVE at +27 → no error.
- **Sync reset mid-burst:** drop `dfi_rstn` during write beat 2 → the array location keeps its old data and `init_done`=0. After re-init, a read of that location returns the old data.

Source files
------------

// File: rtl/dfi_dram_model.sv
// Single-rank DDR3 responder on the DFI command/data port: init tracking, per-bank
// row state, 4-beat bursts against an internal array and a sticky protocol-error flag.
module dfi_dram_model #(
    parameter int unsigned CL       = 6,
    parameter int unsigned CWL      = 6,
    parameter int unsigned T_RCD    = 2,
    parameter int unsigned T_RFC    = 27,
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned COL_BITS = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [14:0] dfi_addr,
    input  logic [2:0]  dfi_bank,
    input  logic        dfi_csn,
    input  logic        dfi_rasn,
    input  logic        dfi_casn,
    input  logic        dfi_wen,
    input  logic        dfi_cke,
    input  logic        dfi_rstn,
    input  logic [31:0] dfi_wdata,
    input  logic        dfi_wmask,
    output logic [31:0] dfi_rdata,
    output logic        init_done,
    output logic        err,
    output logic [2:0]  err_code
);
    localparam int unsigned NBANK = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 3 + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;

    localparam logic [2:0] ERR_INIT    = 3'd1;
    localparam logic [2:0] ERR_DBL_ACT = 3'd2;
    localparam logic [2:0] ERR_CLOSED  = 3'd3;
    localparam logic [2:0] ERR_TRCD    = 3'd4;
    localparam logic [2:0] ERR_TRFC    = 3'd5;
    localparam logic [2:0] ERR_BUSY    = 3'd6;
    localparam logic [2:0] ERR_WMASK   = 3'd7;

    // Timers load T-1 so they read 0 in cycle C+T, the first legal cycle after the command.
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'((T_RFC > 0) ? T_RFC - 1 : 0);
    localparam logic [CNT_W-1:0] RD_FIRST = CNT_W'(CL - 1);
    localparam logic [CNT_W-1:0] RD_END   = CNT_W'(CL + 3);
    localparam logic [CNT_W-1:0] WR_FIRST = CNT_W'(CWL);
    localparam logic [CNT_W-1:0] WR_END   = CNT_W'(CWL + 3);

    typedef enum logic [1:0] {ST_RESET, ST_CKE_WAIT, ST_CONFIG, ST_READY} state_t;

    state_t               state_q;
    logic                 init_done_q;
    logic [3:0]           seen_q, seen_d;
    logic                 zq_q, zq_d;
    logic [14:0]          mr_q [4];
    logic [14:0]          mr_d [4];
    logic [NBANK-1:0]     open_q, open_d;
    logic [ROW_BITS-1:0]  row_q [NBANK];
    logic [ROW_BITS-1:0]  row_d [NBANK];
    logic [CNT_W-1:0]     trcd_q [NBANK];
    logic [CNT_W-1:0]     trcd_d [NBANK];
    logic [CNT_W-1:0]     trfc_q, trfc_d;
    logic                 busy_q, busy_d;
    logic                 wr_q, wr_d;
    logic [CNT_W-1:0]     ph_q, ph_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [127:0]         buf_q, buf_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [2:0]           code_q, code_d;
    logic [127:0]         mem_q [DEPTH];

    logic [3:0]           cmd_c;
    logic                 cmd_nop_c;
    logic                 mem_we_c;
    logic [2:0]           cmd_err_c;
    logic [2:0]           burst_err_c;
    logic [IDX_W-1:0]     rw_idx_c;
    logic [1:0]           rd_beat_c;
    logic [1:0]           wr_beat_c;

    assign cmd_c     = {dfi_csn, dfi_rasn, dfi_casn, dfi_wen};
    assign cmd_nop_c = !(cmd_c inside {CMD_MRS, CMD_ZQCL, CMD_REF, CMD_ACT, CMD_RD, CMD_WR});
    assign rw_idx_c  = {dfi_bank, row_q[dfi_bank], dfi_addr[3 +: COL_BITS]};
    assign rd_beat_c = 2'(ph_q - RD_FIRST);
    assign wr_beat_c = 2'(ph_q - WR_FIRST);

    assign dfi_rdata = rdata_q;
    assign init_done = init_done_q;
    assign err       = err_q;
    assign err_code  = code_q;

    // Command decode, timing checks and burst sequencing.
    always_comb begin
        seen_d      = seen_q;
        zq_d        = zq_q;
        mr_d        = mr_q;
        open_d      = open_q;
        row_d       = row_q;
        busy_d      = busy_q;
        wr_d        = wr_q;
        ph_d        = ph_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        rdata_d     = '0;
        err_d       = err_q;
        code_d      = code_q;
        mem_we_c    = 1'b0;
        cmd_err_c   = '0;
        burst_err_c = '0;
        trfc_d      = (trfc_q != '0) ? trfc_q - CNT_W'(1) : '0;
        for (int b = 0; b < NBANK; b++) begin
            trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - CNT_W'(1) : '0;
        end

        if (!dfi_rstn) begin
            seen_d = '0;
            zq_d   = 1'b0;
            open_d = '0;
            busy_d = 1'b0;
            ph_d   = '0;
            trfc_d = '0;
            for (int b = 0; b < NBANK; b++) begin
                trcd_d[b] = '0;
            end
        end else begin
            if (busy_q) begin
                ph_d = ph_q + CNT_W'(1);
                if (!wr_q) begin
                    if (ph_q >= RD_FIRST && ph_q < RD_END) begin
                        rdata_d = buf_q[{rd_beat_c, 5'd0} +: 32];
                    end
                    if (ph_q == RD_END) begin
                        busy_d = 1'b0;
                    end
                end else if (ph_q >= WR_FIRST) begin
                    if (dfi_wmask) begin
                        buf_d[{wr_beat_c, 5'd0} +: 32] = dfi_wdata;
                    end else begin
                        burst_err_c = ERR_WMASK;
                    end
                    if (ph_q == WR_END) begin
                        mem_we_c = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
            end

            if (dfi_cke) begin
                if (state_q != ST_READY &&
                    cmd_c inside {CMD_ACT, CMD_RD, CMD_WR, CMD_REF}) begin
                    cmd_err_c = ERR_INIT;
                end else if (trfc_q != '0 && !cmd_nop_c) begin
                    cmd_err_c = ERR_TRFC;
                end else if (state_q == ST_CONFIG || state_q == ST_READY) begin
                    case (cmd_c)
                        CMD_MRS: begin
                            mr_d[dfi_bank[1:0]]   = dfi_addr;
                            seen_d[dfi_bank[1:0]] = 1'b1;
                        end
                        CMD_ZQCL: zq_d = 1'b1;
                        CMD_REF: begin
                            if (|open_q) cmd_err_c = ERR_CLOSED;
                            else         trfc_d    = RFC_LOAD;
                        end
                        CMD_ACT: begin
                            if (open_q[dfi_bank]) begin
                                cmd_err_c = ERR_DBL_ACT;
                            end else begin
                                open_d[dfi_bank] = 1'b1;
                                row_d[dfi_bank]  = dfi_addr[ROW_BITS-1:0];
                                trcd_d[dfi_bank] = RCD_LOAD;
                            end
                        end
                        CMD_RD, CMD_WR: begin
                            if (!open_q[dfi_bank]) begin
                                cmd_err_c = ERR_CLOSED;
                            end else if (trcd_q[dfi_bank] != '0) begin
                                cmd_err_c = ERR_TRCD;
                            end else if (busy_q) begin
                                cmd_err_c = ERR_BUSY;
                            end else begin
                                busy_d = 1'b1;
                                wr_d   = (cmd_c == CMD_WR);
                                ph_d   = CNT_W'(1);
                                idx_d  = rw_idx_c;
                                buf_d  = mem_q[rw_idx_c];
                                if (dfi_addr[10]) open_d[dfi_bank] = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        // Only the first error is recorded; command errors win over a same-cycle mask error.
        if (!err_q) begin
            if (cmd_err_c != '0) begin
                err_d  = 1'b1;
                code_d = cmd_err_c;
            end else if (burst_err_c != '0) begin
                err_d  = 1'b1;
                code_d = burst_err_c;
            end
        end
    end

    // Init sequencing: device reset, wait for CKE, collect MR0-3 and ZQCL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RESET;
            init_done_q <= 1'b0;
        end else if (!dfi_rstn) begin
            state_q     <= ST_RESET;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET:    state_q <= ST_CKE_WAIT;
                ST_CKE_WAIT: if (dfi_cke) state_q <= ST_CONFIG;
                ST_CONFIG: begin
                    if (&seen_d && zq_d) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seen_q  <= '0;
            zq_q    <= 1'b0;
            open_q  <= '0;
            trfc_q  <= '0;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            ph_q    <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
            for (int m = 0; m < 4; m++) begin
                mr_q[m] <= '0;
            end
            for (int b = 0; b < NBANK; b++) begin
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
            end
        end else begin
            seen_q  <= seen_d;
            zq_q    <= zq_d;
            mr_q    <= mr_d;
            open_q  <= open_d;
            row_q   <= row_d;
            trcd_q  <= trcd_d;
            trfc_q  <= trfc_d;
            busy_q  <= busy_d;
            wr_q    <= wr_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Array contents survive both resets.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_q] <= buf_d;
        end
    end

endmodule

// File: tb/tb_dfi_dram_model.sv
// Scoreboard bench for dfi_dram_model: init, write/read bursts, protocol errors,
// refresh window and sync reset during a write burst.
module tb_dfi_dram_model;
    localparam int CL  = 6;
    localparam int CWL = 6;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_ZQCL = 4'b0110;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] model [int];

    logic        clk = 1'b0;
    logic        rstn;
    logic [14:0] dfi_addr;
    logic [2:0]  dfi_bank;
    logic        dfi_csn, dfi_rasn, dfi_casn, dfi_wen;
    logic        dfi_cke;
    logic        dfi_rstn;
    logic [31:0] dfi_wdata;
    logic        dfi_wmask;
    logic [31:0] dfi_rdata;
    logic        init_done;
    logic        err;
    logic [2:0]  err_code;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dfi_dram_model dut (
        .clk       (clk),
        .rstn      (rstn),
        .dfi_addr  (dfi_addr),
        .dfi_bank  (dfi_bank),
        .dfi_csn   (dfi_csn),
        .dfi_rasn  (dfi_rasn),
        .dfi_casn  (dfi_casn),
        .dfi_wen   (dfi_wen),
        .dfi_cke   (dfi_cke),
        .dfi_rstn  (dfi_rstn),
        .dfi_wdata (dfi_wdata),
        .dfi_wmask (dfi_wmask),
        .dfi_rdata (dfi_rdata),
        .init_done (init_done),
        .err       (err),
        .err_code  (err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cycle, rdata must match the next scheduled beat or be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                check("rdata_beat", dfi_rdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                check("rdata_idle", dfi_rdata, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int key(input int b, input int r, input int c);
        return b * 4096 + r * 128 + c;
    endfunction

    function automatic logic [14:0] col_addr(input int col);
        return 15'(col << 3) | 15'h0400;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic [14:0] a);
        {dfi_csn, dfi_rasn, dfi_casn, dfi_wen} = c;
        dfi_bank = b;
        dfi_addr = a;
        step(1);
        {dfi_csn, dfi_rasn, dfi_casn, dfi_wen} = C_NOP;
    endtask

    task automatic act(input int b, input int r);
        issue(C_ACT, 3'(b), 15'(r));
    endtask

    task automatic read_burst(input int b, input int r, input int col);
        logic [127:0] w;
        exp_t         e;
        w = model.exists(key(b, r, col)) ? model[key(b, r, col)] : '0;
        for (int i = 0; i < 4; i++) begin
            e.cyc  = cyc + CL + i;
            e.data = w[32*i +: 32];
            exp_q.push_back(e);
        end
        issue(C_RD, 3'(b), col_addr(col));
    endtask

    // pre/post: extra mask-high cycles around the beats; abort: beat at which dfi_rstn drops (4 = none).
    task automatic write_burst(input int b, input int r, input int col, input logic [127:0] data,
                               input logic [3:0] mask, input int pre, input int post, input int abort);
        logic [127:0] w;
        bit           aborted;
        aborted = 1'b0;
        issue(C_WR, 3'(b), col_addr(col));
        step(CWL - 1 - pre);
        dfi_wmask = 1'b1;
        dfi_wdata = 32'hDEAD_BEEF;
        step(pre);
        for (int i = 0; i < 4; i++) begin
            if (!aborted) begin
                if (i == abort) dfi_rstn = 1'b0;
                dfi_wmask = mask[i];
                dfi_wdata = data[32*i +: 32];
                step(1);
                if (i == abort) aborted = 1'b1;
            end
        end
        dfi_wmask = !aborted;
        dfi_wdata = 32'hBAAD_F00D;
        if (!aborted) step(post);
        dfi_wmask = 1'b0;
        if (!aborted) begin
            w = model.exists(key(b, r, col)) ? model[key(b, r, col)] : '0;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) w[32*i +: 32] = data[32*i +: 32];
            end
            model[key(b, r, col)] = w;
        end
    endtask

    task automatic init_seq();
        dfi_rstn = 1'b1;
        step(2);
        dfi_cke = 1'b1;
        step(3);
        issue(C_MRS, 3'd2, 15'h0000);
        issue(C_MRS, 3'd3, 15'h0000);
        issue(C_MRS, 3'd1, 15'h0000);
        issue(C_MRS, 3'd0, 15'h0310);
        check("init_before_zq", 32'(init_done), 32'd0);
        issue(C_ZQCL, 3'd0, 15'h0400);
        check("init_done", 32'(init_done), 32'd1);
        check("init_err", 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        dfi_rstn  = 1'b0;
        dfi_cke   = 1'b0;
        dfi_wmask = 1'b0;
        {dfi_csn, dfi_rasn, dfi_casn, dfi_wen} = C_NOP;
        step(3);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        rstn = 1'b1;
        step(2);
        init_seq();
    endtask

    initial begin
        rstn      = 1'b0;
        dfi_rstn  = 1'b0;
        dfi_cke   = 1'b0;
        dfi_addr  = '0;
        dfi_bank  = '0;
        dfi_wdata = '0;
        dfi_wmask = 1'b0;
        {dfi_csn, dfi_rasn, dfi_casn, dfi_wen} = C_NOP;
        step(2);
        mon_en = 1'b1;

        // Write then read back through auto-precharge, mask held high 9 cycles.
        do_reset();
        act(3, 5);
        step(1);
        write_burst(3, 5, 'h10, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    4'hF, 2, 3, 4);
        act(3, 5);
        step(1);
        read_burst(3, 5, 'h10);
        step(CL + 4);
        check("wr_rd_err", 32'(err), 32'd0);

        // READ one cycle after ACTIVE, then a second error that must not overwrite the code.
        do_reset();
        act(1, 2);
        issue(C_RD, 3'd1, col_addr('h04));
        check("early_rd_err", 32'(err), 32'd1);
        check("early_rd_code", 32'(err_code), 32'd4);
        act(1, 2);
        check("first_err_kept", 32'(err_code), 32'd4);
        step(CL + 4);

        // Second ACTIVE to an open bank.
        do_reset();
        act(0, 1);
        act(0, 2);
        check("dbl_act_code", 32'(err_code), 32'd2);

        // Refresh window: +10 and +26 are illegal, +27 is legal.
        do_reset();
        issue(C_REF, 3'd0, 15'h0);
        step(9);
        act(0, 0);
        check("ref_10_code", 32'(err_code), 32'd5);
        do_reset();
        issue(C_REF, 3'd0, 15'h0);
        step(25);
        act(0, 0);
        check("ref_26_code", 32'(err_code), 32'd5);
        do_reset();
        issue(C_REF, 3'd0, 15'h0);
        step(26);
        act(0, 0);
        check("ref_27_err", 32'(err), 32'd0);
        check("ref_27_code", 32'(err_code), 32'd0);

        // Sync reset during write beat 2 must leave the old data in place.
        act(6, 9);
        step(1);
        write_burst(6, 9, 'h22, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0},
                    4'hF, 0, 0, 4);
        act(6, 9);
        step(1);
        write_burst(6, 9, 'h22, {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0},
                    4'hF, 0, 0, 2);
        check("sync_rst_init_done", 32'(init_done), 32'd0);
        step(1);
        init_seq();
        act(6, 9);
        step(1);
        read_burst(6, 9, 'h22);
        step(CL + 4);
        check("sync_rst_err", 32'(err), 32'd0);

        // Dropped mask on beat 1 keeps that slice and flags the error.
        act(6, 9);
        step(1);
        write_burst(6, 9, 'h22, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0},
                    4'b1101, 0, 0, 4);
        check("wmask_code", 32'(err_code), 32'd7);
        act(6, 9);
        step(1);
        read_burst(6, 9, 'h22);
        step(CL + 4);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
